// File: rtl/detect_sequence_param_fsm_pkg.sv
// Shared types and helpers for the run-time programmable serial pattern detector.
// Holds the detector state encoding and the pattern-length mask builder.
package detect_seq_pkg;

   typedef enum logic [0:0] {
      UNCFG = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam int unsigned MASK_W = 32;

   // Low `len` bits set; len >= MASK_W yields all ones.
   function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
      logic [MASK_W:0] wide;
      if (len >= MASK_W) begin
         len_mask = '1;
      end else begin
         wide     = (33'd1 << len) - 33'd1;
         len_mask = wide[MASK_W-1:0];
      end
   endfunction

endpackage

// File: rtl/detect_sequence_param_fsm_sat_counter.sv
// Up-counter that saturates at a run-time limit; synchronous clear wins over increment.
// Used for both the pattern fill level and the match counter.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] lim,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q_q < lim)) begin
         q_d = q_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/detect_sequence_param_fsm.sv
// Serial bit-pattern detector with run-time pattern/length, optional overlap and
// a saturating match counter. The FSM state is visible on `armed`.
module detect_sequence_param_fsm
   import detect_seq_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               a_valid,
   input  logic               a,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count,
   output logic               armed,
   output logic               cfg_err
);

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   state_e             state_q, state_d;
   logic [MAX_LEN-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               overlap_q, overlap_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic               detected_q, detected_d;
   logic               armed_q, armed_d;
   logic               cfg_err_q, cfg_err_d;

   logic [LEN_W-1:0]   fill;
   logic [LEN_W:0]     fill_plus;
   logic [MAX_LEN-1:0] mask;
   logic [MAX_LEN-1:0] hist_n;
   logic               len_legal;
   logic               accept;
   logic               match;
   logic               fill_clr;

   // cfg_load owns the cycle, so a bit arriving alongside it is dropped.
   assign accept    = (state_q == RUN) && a_valid && !cfg_load;
   assign len_legal = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
   assign hist_n    = {hist_q[MAX_LEN-2:0], a};
   assign mask      = MAX_LEN'(len_mask(32'(len_q)));
   assign fill_plus = {1'b0, fill} + (LEN_W + 1)'(1);
   assign match     = accept && (fill_plus >= {1'b0, len_q})
                      && ((hist_n & mask) == (pattern_q & mask));
   // Non-overlapping mode forgets the matched bits so the next hit needs len fresh bits.
   assign fill_clr  = cfg_load || (match && !overlap_q);

   always_comb begin
      state_d    = state_q;
      pattern_d  = pattern_q;
      len_d      = len_q;
      overlap_d  = overlap_q;
      hist_d     = hist_q;
      cfg_err_d  = cfg_err_q;
      if (cfg_load) begin
         pattern_d = cfg_pattern;
         len_d     = cfg_len;
         overlap_d = cfg_overlap;
         hist_d    = '0;
         state_d   = len_legal ? RUN : UNCFG;
         cfg_err_d = !len_legal;
      end else if (accept) begin
         hist_d = hist_n;
      end
      detected_d = match;
      armed_d    = (state_d == RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= UNCFG;
         pattern_q  <= '0;
         len_q      <= '0;
         overlap_q  <= 1'b0;
         hist_q     <= '0;
         detected_q <= 1'b0;
         armed_q    <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pattern_q  <= pattern_d;
         len_q      <= len_d;
         overlap_q  <= overlap_d;
         hist_q     <= hist_d;
         detected_q <= detected_d;
         armed_q    <= armed_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   sat_counter #(.W(LEN_W)) u_fill (
      .clk (clk),
      .rst (rst),
      .clr (fill_clr),
      .inc (accept),
      .lim (len_q),
      .q   (fill)
   );

   sat_counter #(.W(CNT_W)) u_match_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cfg_load),
      .inc (match),
      .lim ({CNT_W{1'b1}}),
      .q   (match_count)
   );

   assign detected = detected_q;
   assign armed    = armed_q;
   assign cfg_err  = cfg_err_q;

endmodule
